// File: rtl/vga_timing_pkg.sv
// ----------------------------------------------------------------------------
// vga_timing_pkg - 640x480@60 timing constants and scan control record. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package vga_timing_pkg;

   localparam int H_ACT = 640;
   localparam int H_FP  = 16;
   localparam int H_SW  = 96;
   localparam int H_BP  = 48;
   localparam int H_TOT = 800;

   localparam int V_ACT = 480;
   localparam int V_FP  = 10;
   localparam int V_SW  = 2;
   localparam int V_BP  = 33;
   localparam int V_TOT = 525;

   localparam int FB_SCALE = 4;
   localparam int FB_WIDTH = 160;

   typedef struct packed {
      logic active;
      logic hs;
      logic vs;
      logic first;
   } scan_ctl_t;

   localparam scan_ctl_t CTL_IDLE = '{active: 1'b0, hs: 1'b1, vs: 1'b1, first: 1'b0};

endpackage

`default_nettype wire

// File: rtl/fb_addr_calc.sv
// ----------------------------------------------------------------------------
// fb_addr_calc - stored-pixel coordinate to linear framebuffer address. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fb_addr_calc
   import vga_timing_pkg::*;
(
   input  logic [7:0]  x,
   input  logic [6:0]  y,
   output logic [14:0] addr
);

   // The stored width (160) is the sum of two powers of two: 128 + 32.
   localparam int SH_HI = $clog2(FB_WIDTH) - 1;
   localparam int SH_LO = $clog2(FB_WIDTH - (1 << SH_HI));

   assign addr = ({8'b0, y} << SH_HI) + ({8'b0, y} << SH_LO) + {7'b0, x};

endmodule

`default_nettype wire

// File: rtl/fb_scanout.sv
// ----------------------------------------------------------------------------
// fb_scanout - VGA scanout of a 3-bit 160x120 framebuffer, 2-stage pipe. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fb_scanout
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE = H_ACT,
   parameter int V_ACTIVE = V_ACT,
   parameter int SCALE    = FB_SCALE
)(
   input  logic        CLOCK_50,
   input  logic        reset_n,
   output logic [14:0] mem_addr,
   input  logic [2:0]  mem_data,
   output logic        VGA_CLK,
   output logic        VGA_HS,
   output logic        VGA_VS,
   output logic        VGA_BLANK_N,
   output logic        VGA_SYNC_N,
   output logic [9:0]  VGA_R,
   output logic [9:0]  VGA_G,
   output logic [9:0]  VGA_B,
   output logic        frame_start
);

   localparam int H_TOTAL      = H_TOT - H_ACT + H_ACTIVE;
   localparam int V_TOTAL      = V_TOT - V_ACT + V_ACTIVE;
   localparam int H_SYNC_FIRST = H_ACTIVE + H_FP;
   localparam int H_SYNC_LAST  = H_SYNC_FIRST + H_SW - 1;
   localparam int V_SYNC_FIRST = V_ACTIVE + V_FP;
   localparam int V_SYNC_LAST  = V_SYNC_FIRST + V_SW - 1;
   // SCALE must be a power of two so the divide is a plain shift.
   localparam int SHIFT        = $clog2(SCALE);

   logic        pix_en;
   logic [9:0]  hcount;
   logic [9:0]  vcount;
   logic        h_last;
   logic        v_last;
   logic [7:0]  fb_x;
   logic [6:0]  fb_y;
   logic [14:0] fb_addr;
   logic [2:0]  pix_s2;
   scan_ctl_t   ctl_now;
   scan_ctl_t   ctl_s1;
   scan_ctl_t   ctl_s2;

   // VGA_CLK lags pix_en by one cycle, so it is high whenever pix_en is low.
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         pix_en  <= 1'b0;
         VGA_CLK <= 1'b0;
      end else begin
         pix_en  <= ~pix_en;
         VGA_CLK <= pix_en;
      end
   end

   assign h_last = (hcount == 10'(H_TOTAL - 1));
   assign v_last = (vcount == 10'(V_TOTAL - 1));

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         hcount <= '0;
         vcount <= '0;
      end else if (pix_en) begin
         if (h_last) begin
            hcount <= '0;
            vcount <= v_last ? '0 : vcount + 10'd1;
         end else begin
            hcount <= hcount + 10'd1;
         end
      end
   end

   always_comb begin
      ctl_now        = CTL_IDLE;
      ctl_now.active = (hcount < 10'(H_ACTIVE)) && (vcount < 10'(V_ACTIVE));
      ctl_now.hs     = !((hcount >= 10'(H_SYNC_FIRST)) && (hcount <= 10'(H_SYNC_LAST)));
      ctl_now.vs     = !((vcount >= 10'(V_SYNC_FIRST)) && (vcount <= 10'(V_SYNC_LAST)));
      ctl_now.first  = (hcount == '0) && (vcount == '0);
   end

   assign fb_x = 8'(hcount >> SHIFT);
   assign fb_y = 7'(vcount >> SHIFT);

   fb_addr_calc u_addr_calc (
      .x    (fb_x),
      .y    (fb_y),
      .addr (fb_addr)
   );

   // Stage 1 issues the address, stage 2 captures the returned word,
   // then the output registers present it alongside the matching syncs.
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         mem_addr    <= '0;
         ctl_s1      <= CTL_IDLE;
         ctl_s2      <= CTL_IDLE;
         pix_s2      <= '0;
         VGA_HS      <= 1'b1;
         VGA_VS      <= 1'b1;
         VGA_BLANK_N <= 1'b0;
         VGA_R       <= '0;
         VGA_G       <= '0;
         VGA_B       <= '0;
      end else if (pix_en) begin
         if (ctl_now.active) begin
            mem_addr <= fb_addr;
         end
         ctl_s1      <= ctl_now;
         ctl_s2      <= ctl_s1;
         pix_s2      <= mem_data;
         VGA_HS      <= ctl_s2.hs;
         VGA_VS      <= ctl_s2.vs;
         VGA_BLANK_N <= ctl_s2.active;
         VGA_R       <= {10{pix_s2[2] & ctl_s2.active}};
         VGA_G       <= {10{pix_s2[1] & ctl_s2.active}};
         VGA_B       <= {10{pix_s2[0] & ctl_s2.active}};
      end
   end

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         frame_start <= 1'b0;
      end else begin
         frame_start <= pix_en & ctl_s2.first;
      end
   end

   assign VGA_SYNC_N = 1'b0;

endmodule

`default_nettype wire
